// File: rtl/mig_apm_pkg.sv
// Shared types and helpers for the MIG per-DSid bandwidth sampler.
// Optional feature macro: MIG_APM_SATURATE_EN (live counters saturate instead of wrapping).
package mig_apm_pkg;

    localparam logic DIR_RD = 1'b0;
    localparam logic DIR_WR = 1'b1;

    typedef enum logic {S_IDLE, S_EMIT} apm_state_e;

    function automatic logic [31:0] apm_addr(input logic [3:0] dsid, input logic dir);
        return {24'h0, dsid, dir, 3'b000};
    endfunction

    // Widened to 16 bits before the shift so a 256-beat, 128-byte burst (32768) fits.
    function automatic logic [15:0] req_bytes(input logic [7:0] len, input logic [2:0] size);
        logic [15:0] beats;
        beats = {8'h00, len} + 16'd1;
        return beats << size;
    endfunction

endpackage

// File: rtl/mig_apm_if.sv
// Snooped AXI address-channel handshakes in, APM record stream out.
// The master side drives the snooped channels; the sampler is the slave.
interface mig_apm_if #(
    parameter int ID_WIDTH = 5
);
    logic                mon_arvalid;
    logic                mon_arready;
    logic [ID_WIDTH-1:0] mon_arid;
    logic [7:0]          mon_arlen;
    logic [2:0]          mon_arsize;
    logic                mon_awvalid;
    logic                mon_awready;
    logic [ID_WIDTH-1:0] mon_awid;
    logic [7:0]          mon_awlen;
    logic [2:0]          mon_awsize;
    logic                APM_VALID;
    logic [31:0]         APM_ADDR;
    logic [31:0]         APM_DATA;

    modport master (
        output mon_arvalid, mon_arready, mon_arid, mon_arlen, mon_arsize,
        output mon_awvalid, mon_awready, mon_awid, mon_awlen, mon_awsize,
        input  APM_VALID, APM_ADDR, APM_DATA
    );

    modport slave (
        input  mon_arvalid, mon_arready, mon_arid, mon_arlen, mon_arsize,
        input  mon_awvalid, mon_awready, mon_awid, mon_awlen, mon_awsize,
        output APM_VALID, APM_ADDR, APM_DATA
    );
endinterface

// File: rtl/mig_apm_accum.sv
// One direction's bank of per-DSid live byte counters plus their window snapshot.
// MIG_APM_SATURATE_EN: counters stick at all-ones; otherwise they wrap.
module mig_apm_accum
    import mig_apm_pkg::*;
#(
    parameter int NUM_DSID = 3,
    parameter int ID_WIDTH = 5,
    parameter int CNT_W    = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               hs_i,
    input  logic [ID_WIDTH-1:0]                dsid_i,
    input  logic [15:0]                        bytes_i,
    input  logic                               snap_i,
    output logic [NUM_DSID-1:0][CNT_W-1:0]     live_o,
    output logic [NUM_DSID-1:0][CNT_W-1:0]     shadow_o
);

    localparam int SUM_W = ((CNT_W > 16) ? CNT_W : 16) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = (SUM_W'(1) << CNT_W) - SUM_W'(1);

    logic [NUM_DSID-1:0][CNT_W-1:0] live_q, live_d;
    logic [NUM_DSID-1:0][CNT_W-1:0] shadow_q;
    logic [SUM_W-1:0]               base, sum;

    // A snapshot clears the bank, so a same-cycle handshake starts the new window.
    always_comb begin
        live_d = live_q;
        base   = '0;
        sum    = '0;
        for (int d = 0; d < NUM_DSID; d++) begin
            base = snap_i ? '0 : SUM_W'(live_q[d]);
            sum  = base;
            if (hs_i && (dsid_i == ID_WIDTH'(d))) begin
                sum = base + SUM_W'(bytes_i);
            end
`ifdef MIG_APM_SATURATE_EN
            if (sum > CNT_MAX) begin
                sum = CNT_MAX;
            end
`endif
            live_d[d] = sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            live_q   <= '0;
            shadow_q <= '0;
        end else begin
            live_q <= live_d;
            if (snap_i) begin
                shadow_q <= live_q;
            end
        end
    end

    assign live_o   = live_q;
    assign shadow_o = shadow_q;

endmodule

// File: rtl/mig_apm_sampler.sv
// Per-DSid read/write byte sampler: windows the AR/AW traffic and streams APM records.
// Optional feature macro: MIG_APM_SATURATE_EN (see mig_apm_accum).
module mig_apm_sampler
    import mig_apm_pkg::*;
#(
    parameter int NUM_DSID      = 3,
    parameter int ID_WIDTH      = 5,
    parameter int WINDOW_CYCLES = 100000,
    parameter int CNT_W         = 32
) (
    input  logic    aclk,
    input  logic    reset,
    input  logic    enable,
    output logic    window_tick,
    mig_apm_if.slave bus
);

    localparam int NREC = 2 * NUM_DSID;
    localparam int IW   = $clog2(NREC + 1);
    localparam int WW   = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;

    if (WINDOW_CYCLES < 2 * NUM_DSID + 2) begin : g_bad_window
        $error("mig_apm_sampler: WINDOW_CYCLES too short for one full emission");
    end
    if (NUM_DSID > 16) begin : g_bad_dsid
        $error("mig_apm_sampler: record address holds only a 4-bit DSid");
    end

    logic [WW-1:0] win_q;
    logic          tick;
    logic          ar_hs, aw_hs;
    logic [15:0]   ar_bytes, aw_bytes;

    logic [NUM_DSID-1:0][CNT_W-1:0] rd_live, rd_shadow, wr_live, wr_shadow;

    apm_state_e  state_q;
    logic [IW-1:0] idx_q;
    logic        valid_q;
    logic [31:0] addr_q, data_q;

    logic [IW-1:0]    rec_dsid;
    logic             rec_dir;
    logic [CNT_W-1:0] rec_data;

    assign tick        = enable && (win_q == '0);
    assign window_tick = tick;
    assign ar_hs       = enable && bus.mon_arvalid && bus.mon_arready;
    assign aw_hs       = enable && bus.mon_awvalid && bus.mon_awready;
    assign ar_bytes    = req_bytes(bus.mon_arlen, bus.mon_arsize);
    assign aw_bytes    = req_bytes(bus.mon_awlen, bus.mon_awsize);

    always_ff @(posedge aclk) begin
        if (reset) begin
            win_q <= WW'(WINDOW_CYCLES - 1);
        end else if (enable) begin
            win_q <= (win_q == '0) ? WW'(WINDOW_CYCLES - 1) : win_q - WW'(1);
        end
    end

    mig_apm_accum #(.NUM_DSID(NUM_DSID), .ID_WIDTH(ID_WIDTH), .CNT_W(CNT_W)) u_rd (
        .clk(aclk), .rst(reset), .hs_i(ar_hs), .dsid_i(bus.mon_arid),
        .bytes_i(ar_bytes), .snap_i(tick), .live_o(rd_live), .shadow_o(rd_shadow)
    );

    mig_apm_accum #(.NUM_DSID(NUM_DSID), .ID_WIDTH(ID_WIDTH), .CNT_W(CNT_W)) u_wr (
        .clk(aclk), .rst(reset), .hs_i(aw_hs), .dsid_i(bus.mon_awid),
        .bytes_i(aw_bytes), .snap_i(tick), .live_o(wr_live), .shadow_o(wr_shadow)
    );

    always_comb begin
        rec_dsid = idx_q >> 1;
        rec_dir  = idx_q[0];
        rec_data = '0;
        for (int d = 0; d < NUM_DSID; d++) begin
            if (rec_dsid == IW'(d)) begin
                rec_data = rec_dir ? wr_shadow[d] : rd_shadow[d];
            end
        end
    end

    // Record 0 is loaded on the tick edge itself, straight from the live value being snapshotted;
    // idx_q always names the next record to present.
    always_ff @(posedge aclk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (tick) begin
                        state_q <= S_EMIT;
                        idx_q   <= IW'(1);
                        valid_q <= 1'b1;
                        addr_q  <= apm_addr(4'd0, DIR_RD);
                        data_q  <= 32'(rd_live[0]);
                    end
                end
                S_EMIT: begin
                    if (idx_q == IW'(NREC)) begin
                        state_q <= S_IDLE;
                        idx_q   <= '0;
                        valid_q <= 1'b0;
                        addr_q  <= '0;
                        data_q  <= '0;
                    end else begin
                        idx_q   <= idx_q + IW'(1);
                        valid_q <= 1'b1;
                        addr_q  <= apm_addr(4'(rec_dsid), rec_dir);
                        data_q  <= 32'(rec_data);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.APM_VALID = valid_q;
    assign bus.APM_ADDR  = addr_q;
    assign bus.APM_DATA  = data_q;

endmodule

// File: tb/tb_mig_apm_sampler.sv
// Scoreboard bench for mig_apm_sampler: a cycle model of the window and per-DSid counters
// queues the expected records at each expiry and pops them as the DUT streams them.
module tb_mig_apm_sampler;

   localparam int NUM_DSID = 3;
   localparam int ID_WIDTH = 5;
   localparam int WINDOW   = 40;
   localparam int CNT_W    = 8;
   localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } rec_t;

   logic aclk = 1'b0;
   logic reset;
   logic enable;
   logic window_tick;

   rec_t   expQ[$];
   longint mLive[2][NUM_DSID];
   int     mWin;
   int     checkCount = 0;
   int     errorCount = 0;
   bit     chkOn = 1'b0;

   mig_apm_if #(.ID_WIDTH(ID_WIDTH)) bus();

   mig_apm_sampler #(
      .NUM_DSID(NUM_DSID), .ID_WIDTH(ID_WIDTH), .WINDOW_CYCLES(WINDOW), .CNT_W(CNT_W)
   ) dut (
      .aclk(aclk), .reset(reset), .enable(enable), .window_tick(window_tick), .bus(bus)
   );

   always #5 aclk = ~aclk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      if (obs !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic longint addBytes(input longint cur, input int len, input int size);
      longint v;
      v = cur + longint'((len + 1) * (1 << size));
`ifdef MIG_APM_SATURATE_EN
      if (v > CNT_MAX) v = CNT_MAX;
`else
      v = v % (CNT_MAX + 1);
`endif
      return v;
   endfunction

   function automatic void clearModel();
      for (int r = 0; r < 2; r++)
         for (int d = 0; d < NUM_DSID; d++)
            mLive[r][d] = 0;
   endfunction

   // Checks the DUT outputs for this cycle first, then advances the model to the next cycle.
   always @(negedge aclk) begin
      if (chkOn) begin
         checkOutput("apm_valid", 32'(bus.APM_VALID), 32'(expQ.size() > 0));
         if (bus.APM_VALID === 1'b1 && expQ.size() > 0) begin
            rec_t r;
            r = expQ.pop_front();
            checkOutput("rec_addr", bus.APM_ADDR, r.addr);
            checkOutput("rec_data", bus.APM_DATA, r.data);
         end else if (bus.APM_VALID !== 1'b1) begin
            checkOutput("idle_addr", bus.APM_ADDR, 32'h0);
            checkOutput("idle_data", bus.APM_DATA, 32'h0);
         end
         checkOutput("window_tick", 32'(window_tick), 32'(enable && mWin == 0));

         if (reset) begin
            expQ.delete();
            clearModel();
            mWin = WINDOW - 1;
         end else if (enable) begin
            if (mWin == 0) begin
               checkOutput("leftover_records", 32'(expQ.size()), 32'd0);
               for (int i = 0; i < 2 * NUM_DSID; i++)
                  expQ.push_back('{addr: 32'((i >> 1) * 16 + (i & 1) * 8),
                                   data: 32'(mLive[i & 1][i >> 1])});
               clearModel();
               mWin = WINDOW - 1;
            end else begin
               mWin--;
            end
            if (bus.mon_arvalid && bus.mon_arready && int'(bus.mon_arid) < NUM_DSID)
               mLive[0][bus.mon_arid] = addBytes(mLive[0][bus.mon_arid],
                                                 int'(bus.mon_arlen), int'(bus.mon_arsize));
            if (bus.mon_awvalid && bus.mon_awready && int'(bus.mon_awid) < NUM_DSID)
               mLive[1][bus.mon_awid] = addBytes(mLive[1][bus.mon_awid],
                                                 int'(bus.mon_awlen), int'(bus.mon_awsize));
         end
      end
   end

   task automatic idleCycles(input int n);
      repeat (n) begin
         @(posedge aclk);
         #1;
      end
   endtask

   // Drives one cycle of AR/AW activity, then returns the channels to idle.
   task automatic applyStimulus(input bit arv, input bit arr, input logic [4:0] arid,
                                input logic [7:0] arlen, input logic [2:0] arsize,
                                input bit awv, input bit awr, input logic [4:0] awid,
                                input logic [7:0] awlen, input logic [2:0] awsize);
      bus.mon_arvalid = arv;  bus.mon_arready = arr;  bus.mon_arid = arid;
      bus.mon_arlen   = arlen; bus.mon_arsize = arsize;
      bus.mon_awvalid = awv;  bus.mon_awready = awr;  bus.mon_awid = awid;
      bus.mon_awlen   = awlen; bus.mon_awsize = awsize;
      idleCycles(1);
      bus.mon_arvalid = 1'b0; bus.mon_arready = 1'b0;
      bus.mon_awvalid = 1'b0; bus.mon_awready = 1'b0;
   endtask

   // Leaves the caller at the start of an expiry cycle.
   task automatic waitTick();
      int n = 0;
      while (window_tick !== 1'b1 && n < 3 * WINDOW) begin
         idleCycles(1);
         n++;
      end
      checkOutput("tick_seen", 32'(window_tick), 32'd1);
   endtask

   initial begin
      reset = 1'b1;
      enable = 1'b0;
      bus.mon_arvalid = 1'b0; bus.mon_arready = 1'b0; bus.mon_arid = '0;
      bus.mon_arlen = '0; bus.mon_arsize = '0;
      bus.mon_awvalid = 1'b0; bus.mon_awready = 1'b0; bus.mon_awid = '0;
      bus.mon_awlen = '0; bus.mon_awsize = '0;
      clearModel();
      mWin = WINDOW - 1;
      idleCycles(3);
      checkOutput("rst_valid", 32'(bus.APM_VALID), 32'd0);
      checkOutput("rst_addr", bus.APM_ADDR, 32'd0);
      checkOutput("rst_data", bus.APM_DATA, 32'd0);
      checkOutput("rst_tick", 32'(window_tick), 32'd0);
      reset = 1'b0;
      enable = 1'b1;
      chkOn = 1'b1;

      // Window 0: one 32-byte read on DSid 1, a stalled request and out-of-range ids.
      idleCycles(2);
      applyStimulus(1, 1, 5'd1, 8'd3, 3'd3, 0, 0, 5'd0, 8'd0, 3'd0);
      applyStimulus(1, 0, 5'd0, 8'd7, 3'd3, 0, 0, 5'd0, 8'd0, 3'd0);
      applyStimulus(1, 1, 5'd5, 8'd7, 3'd3, 1, 1, 5'd7, 8'd3, 3'd2);
      waitTick();
      idleCycles(1);

      // Window 1: simultaneous AR/AW on DSid 2, maximal write burst, then a read in the expiry cycle.
      idleCycles(8);
      applyStimulus(1, 1, 5'd2, 8'd0, 3'd2, 1, 1, 5'd2, 8'd7, 3'd3);
      applyStimulus(0, 0, 5'd0, 8'd0, 3'd0, 1, 1, 5'd1, 8'd255, 3'd7);
      waitTick();
      applyStimulus(1, 1, 5'd0, 8'd7, 3'd3, 0, 0, 5'd0, 8'd0, 3'd0);

      // Window 2: enable dropped mid-emission; a handshake while disabled must be ignored.
      enable = 1'b0;
      applyStimulus(1, 1, 5'd0, 8'd7, 3'd3, 1, 1, 5'd1, 8'd0, 3'd0);
      idleCycles(5);
      enable = 1'b1;
      waitTick();
      idleCycles(1);

      // Window 3: eight back-to-back 64-byte reads on DSid 0, then reset on the 3rd emission cycle.
      idleCycles(8);
      repeat (8) applyStimulus(1, 1, 5'd0, 8'd7, 3'd3, 0, 0, 5'd0, 8'd0, 3'd0);
      applyStimulus(0, 0, 5'd0, 8'd0, 3'd0, 1, 1, 5'd1, 8'd1, 3'd1);
      waitTick();
      idleCycles(3);
      reset = 1'b1;
      idleCycles(1);
      reset = 1'b0;

      // Post-reset window runs full length.
      applyStimulus(1, 1, 5'd2, 8'd1, 3'd0, 0, 0, 5'd0, 8'd0, 3'd0);
      waitTick();
      idleCycles(2 * NUM_DSID + 4);

      checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
      chkOn = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
